// File: rtl/interlock_input_conditioner.sv
// Synchronizes and debounces the airlock board inputs (four switches, two
// active-low keys) into clean levels and single-cycle press strobes.
module interlock_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       Key1,
  input  logic       Key2,
  output logic [3:0] SW_stable,
  output logic       Key1_held,
  output logic       Key2_held,
  output logic       Key1_pulse,
  output logic       Key2_pulse
);

  localparam int NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Bits 5:4 are the keys; they idle high (released), the switches idle low.
  localparam logic [NCH-1:0] RST_VAL = 6'b110000;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   fall;
  logic [CNT_W-1:0] cnt [NCH];

  assign raw = {Key2, Key1, SW3, SW2, SW1, SW0};

  // A debounced 1->0 transition happens exactly when the counter completes
  // while the synchronized level is low and the stable level is high.
  always_comb begin
    fall = '0;
    for (int i = 0; i < NCH; i++) begin
      fall[i] = stable[i] & ~s2[i] & (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1         <= RST_VAL;
      s2         <= RST_VAL;
      stable     <= RST_VAL;
      Key1_pulse <= 1'b0;
      Key2_pulse <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      Key1_pulse <= fall[4];
      Key2_pulse <= fall[5];
    end
  end

  assign SW_stable = stable[3:0];
  assign Key1_held = ~stable[4];
  assign Key2_held = ~stable[5];

endmodule

// File: tb/tb_interlock_input_conditioner.sv
// Scoreboarded bench for interlock_input_conditioner: stimulus queues the
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_interlock_input_conditioner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       SW0, SW1, SW2, SW3, Key1, Key2;
  logic [3:0] SW_stable;
  logic       Key1_held, Key2_held, Key1_pulse, Key2_pulse;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  interlock_input_conditioner #(.DEBOUNCE_CYCLES(2), .CNT_W(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SW0        (SW0),
    .SW1        (SW1),
    .SW2        (SW2),
    .SW3        (SW3),
    .Key1       (Key1),
    .Key2       (Key2),
    .SW_stable  (SW_stable),
    .Key1_held  (Key1_held),
    .Key2_held  (Key2_held),
    .Key1_pulse (Key1_pulse),
    .Key2_pulse (Key2_pulse)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic push(input int t, input logic [3:0] sw, input logic h1, input logic h2,
                      input logic p1, input logic p2, input string nm);
    exp_t e;
    e.cyc  = t;
    e.exp  = {sw, h1, h2, p1, p2};
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] v);
    {SW3, SW2, SW1, SW0} = v;
  endtask

  // Output vector: {SW_stable, Key1_held, Key2_held, Key1_pulse, Key2_pulse}
  always @(negedge Clock) begin
    logic [7:0] act;
    exp_t       e;
    act = {SW_stable, Key1_held, Key2_held, Key1_pulse, Key2_pulse};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: cycle %0d got %b required %b", e.name, cyc, act, e.exp);
      end
    end
  end

  initial begin
    int c, r;
    set_sw(4'b1111);
    Key1 = 1'b0;
    Key2 = 1'b0;

    // Reset held with all inputs active, then released.
    tick(3);
    push(cyc, 4'b0000, 0, 0, 0, 0, "reset_clear");
    tick(1);
    c = cyc;
    Reset = 1'b1;
    push(c + 3, 4'b0000, 0, 0, 0, 0, "release_pre");
    push(c + 4, 4'b1111, 1, 1, 1, 1, "release_edge4");
    push(c + 5, 4'b1111, 1, 1, 0, 0, "release_pulse_end");
    tick(6);

    // Release keys and drop switches together.
    c = cyc;
    Key1 = 1'b1;
    Key2 = 1'b1;
    set_sw(4'b0000);
    push(c + 3, 4'b1111, 1, 1, 0, 0, "keys_up_pre");
    push(c + 4, 4'b0000, 0, 0, 0, 0, "keys_up");
    tick(6);

    // Key1 pressed for 3 cycles.
    c = cyc;
    Key1 = 1'b0;
    push(c + 3, 4'b0000, 0, 0, 0, 0, "k1_press_pre");
    push(c + 4, 4'b0000, 1, 0, 1, 0, "k1_press_pulse");
    push(c + 5, 4'b0000, 1, 0, 0, 0, "k1_pulse_one_cycle");
    push(c + 6, 4'b0000, 1, 0, 0, 0, "k1_still_held");
    push(c + 7, 4'b0000, 0, 0, 0, 0, "k1_released");
    push(c + 8, 4'b0000, 0, 0, 0, 0, "k1_no_release_pulse");
    tick(3);
    Key1 = 1'b1;
    tick(8);

    // Single-cycle glitch on Key1 must be rejected.
    c = cyc;
    for (int t = 1; t <= 6; t++) push(c + t, 4'b0000, 0, 0, 0, 0, "k1_glitch");
    Key1 = 1'b0;
    tick(1);
    Key1 = 1'b1;
    tick(8);

    // Both keys pressed together and held 20 cycles: one pulse each.
    c = cyc;
    for (int t = 1; t <= 26; t++) begin
      logic h, p;
      h = (t >= 4) && (t <= 23);
      p = (t == 4);
      push(c + t, 4'b0000, h, h, p, p, "long_hold_both");
    end
    Key1 = 1'b0;
    Key2 = 1'b0;
    tick(20);
    Key1 = 1'b1;
    Key2 = 1'b1;
    tick(10);

    // SW2 rises, SW3 rises 8 cycles later.
    c = cyc;
    push(c + 3, 4'b0000, 0, 0, 0, 0, "sw2_pre");
    push(c + 4, 4'b0100, 0, 0, 0, 0, "sw2_rise");
    push(c + 11, 4'b0100, 0, 0, 0, 0, "sw3_pre");
    push(c + 12, 4'b1100, 0, 0, 0, 0, "sw3_rise");
    SW2 = 1'b1;
    tick(8);
    SW3 = 1'b1;
    tick(8);

    // SW3 dips for one cycle: no change.
    c = cyc;
    for (int t = 1; t <= 6; t++) push(c + t, 4'b1100, 0, 0, 0, 0, "sw3_glitch");
    SW3 = 1'b0;
    tick(1);
    SW3 = 1'b1;
    tick(8);

    // Reset mid-debounce of a Key1 press (counter at 1).
    c = cyc;
    push(c + 2, 4'b1100, 0, 0, 0, 0, "pre_mid_reset");
    Key1 = 1'b0;
    tick(3);
    push(cyc, 4'b0000, 0, 0, 0, 0, "async_clear");
    Reset = 1'b0;
    tick(3);
    r = cyc;
    Reset = 1'b1;
    for (int t = 0; t <= 3; t++) push(r + t, 4'b0000, 0, 0, 0, 0, "post_reset_wait");
    push(r + 4, 4'b1100, 1, 0, 1, 0, "post_reset_edge4");
    push(r + 5, 4'b1100, 1, 0, 0, 0, "post_reset_pulse_end");
    tick(8);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
